// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
//   Bundles every non-clock/reset signal of the writeback stage.
//   Memory-stage side : valid_i/ready_o handshake plus instruction fields
//                       (RegWrite_i, MemToReg_i, rd_i, funct3_i, addr_lo_i,
//                       alu_result_i, mem_rdata_i).
//   Register-file side: WriteValid/WriteAddress/WriteData, granted by wr_ready_i.
//   Hazard query      : hz_rs1_i/hz_rs2_i in, hazard_o out.
//   modport slave  - used by the writeback stage itself.
//   modport master - used by whatever drives the stage (pipeline or bench).
// -----------------------------------------------------------------------------
interface writeback_stage_if;
    logic        valid_i;
    logic        ready_o;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic [4:0]  rd_i;
    logic [2:0]  funct3_i;
    logic [1:0]  addr_lo_i;
    logic [31:0] alu_result_i;
    logic [31:0] mem_rdata_i;
    logic        WriteValid;
    logic [4:0]  WriteAddress;
    logic [31:0] WriteData;
    logic        wr_ready_i;
    logic [4:0]  hz_rs1_i;
    logic [4:0]  hz_rs2_i;
    logic        hazard_o;

    modport slave (
        input  valid_i, RegWrite_i, MemToReg_i, rd_i, funct3_i, addr_lo_i,
               alu_result_i, mem_rdata_i, wr_ready_i, hz_rs1_i, hz_rs2_i,
        output ready_o, WriteValid, WriteAddress, WriteData, hazard_o
    );

    modport master (
        output valid_i, RegWrite_i, MemToReg_i, rd_i, funct3_i, addr_lo_i,
               alu_result_i, mem_rdata_i, wr_ready_i, hz_rs1_i, hz_rs2_i,
        input  ready_o, WriteValid, WriteAddress, WriteData, hazard_o
    );
endinterface

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Final pipeline stage. Formats load data by funct3/byte offset, selects
//   load data or ALU result and queues register writes in a small circular
//   write buffer that drains into the register-file write port whenever
//   wr_ready_i grants it. A combinational hazard query reports pending writes.
//
//   Ports:
//     clk_i      clock
//     reset_i    synchronous active-high reset
//     bus        writeback_stage_if.slave (handshake, write port, hazard query)
//     instret_o  [63:0] retired-instruction counter (only with WB_INSTRET_EN)
//
//   Parameter DEPTH: write-buffer entries (2, 4 or 8).
//   Optional feature macro: WB_INSTRET_EN adds the instret_o counter.
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    writeback_stage_if.slave   bus
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]        instret_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic [4:0]  rd_mem_q   [DEPTH];
    logic [31:0] data_mem_q [DEPTH];

    logic        full, empty, accept, writes, enq, deq;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] fmt_data, wr_data;

    // Load formatting
    always_comb begin
        case (bus.addr_lo_i)
            2'd0:    ld_byte = bus.mem_rdata_i[7:0];
            2'd1:    ld_byte = bus.mem_rdata_i[15:8];
            2'd2:    ld_byte = bus.mem_rdata_i[23:16];
            default: ld_byte = bus.mem_rdata_i[31:24];
        endcase
        // Halfword select uses only the upper offset bit; misaligned bit 0 is ignored.
        ld_half = bus.addr_lo_i[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        case (bus.funct3_i)
            3'b000:  fmt_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  fmt_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  fmt_data = {24'd0, ld_byte};
            3'b101:  fmt_data = {16'd0, ld_half};
            default: fmt_data = bus.mem_rdata_i;
        endcase
        wr_data = bus.MemToReg_i ? fmt_data : bus.alu_result_i;
    end

    // Handshake and buffer control. A full buffer refuses input even if it
    // drains this cycle, so ready_o never depends on wr_ready_i.
    always_comb begin
        full   = (count_q == CNT_W'(DEPTH));
        empty  = (count_q == '0);
        accept = bus.valid_i && !reset_i && !full;
        writes = bus.RegWrite_i && (bus.rd_i != 5'd0);
        enq    = accept && writes;
        deq    = !reset_i && !empty && bus.wr_ready_i;
    end

    // Next-state: pointers, count and the registered head entry
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (count_d != '0) begin
            // The new head is the entry being written right now only when it
            // lands in the slot the read pointer moves to (buffer otherwise empty).
            if (enq && (wr_ptr_q == rd_ptr_d)) begin
                waddr_d = bus.rd_i;
                wdata_d = wr_data;
            end else begin
                waddr_d = rd_mem_q[rd_ptr_d];
                wdata_d = data_mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Buffer storage; contents are meaningful only inside the valid window.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            rd_mem_q[wr_ptr_q]   <= bus.rd_i;
            data_mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Hazard: an entry is live when its distance from the head is below count.
    logic [DEPTH-1:0] hit;
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hz
            logic [PTR_W-1:0] offs;
            logic             live;
            assign offs = PTR_W'(gi) - rd_ptr_q;
            assign live = (CNT_W'(offs) < count_q);
            assign hit[gi] = live &&
                (((bus.hz_rs1_i != 5'd0) && (rd_mem_q[gi] == bus.hz_rs1_i)) ||
                 ((bus.hz_rs2_i != 5'd0) && (rd_mem_q[gi] == bus.hz_rs2_i)));
        end
    endgenerate

    assign bus.ready_o      = !reset_i && !full;
    assign bus.WriteValid   = !reset_i && !empty;
    assign bus.WriteAddress = waddr_q;
    assign bus.WriteData    = wdata_q;
    assign bus.hazard_o     = !reset_i && (|hit);

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;
    logic        retire_nw;

    always_comb begin
        retire_nw = accept && !writes;
        instret_d = instret_q + 64'(retire_nw) + 64'(deq);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//   Directed bench for writeback_stage (DEPTH=2): a table of single-instruction
//   load/ALU vectors plus hand-written sequences for drop, backpressure,
//   streaming and reset-mid-drain behaviour.
// -----------------------------------------------------------------------------
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_stage_if bus();

`ifdef WB_INSTRET_EN
    logic [63:0] instret;
    longint unsigned exp_instret = 0;
`endif

    writeback_stage #(.DEPTH(2)) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .bus       (bus)
`ifdef WB_INSTRET_EN
        ,
        .instret_o (instret)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_instret(input string name);
`ifdef WB_INSTRET_EN
        check(name, instret, exp_instret);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] alu, input logic [31:0] rdata);
        bus.valid_i      = v;
        bus.RegWrite_i   = rw;
        bus.MemToReg_i   = m2r;
        bus.rd_i         = rd;
        bus.funct3_i     = f3;
        bus.addr_lo_i    = off;
        bus.alu_result_i = alu;
        bus.mem_rdata_i  = rdata;
    endtask

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        exp_wv;
        logic [31:0] exp_data;
    } vec_t;

    localparam logic [31:0] W = 32'h80FF7F01;
    vec_t vecs[16];
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  3'b000, 2'd3, 32'h0, W, 1'b1, 32'hFFFFFF80};
        vecs[1]  = '{1'b1, 1'b1, 5'd6,  3'b000, 2'd0, 32'h0, W, 1'b1, 32'h00000001};
        vecs[2]  = '{1'b1, 1'b1, 5'd7,  3'b000, 2'd1, 32'h0, W, 1'b1, 32'h0000007F};
        vecs[3]  = '{1'b1, 1'b1, 5'd8,  3'b000, 2'd2, 32'h0, W, 1'b1, 32'hFFFFFFFF};
        vecs[4]  = '{1'b1, 1'b1, 5'd9,  3'b100, 2'd3, 32'h0, W, 1'b1, 32'h00000080};
        vecs[5]  = '{1'b1, 1'b1, 5'd10, 3'b100, 2'd2, 32'h0, W, 1'b1, 32'h000000FF};
        vecs[6]  = '{1'b1, 1'b1, 5'd11, 3'b001, 2'd0, 32'h0, W, 1'b1, 32'h00007F01};
        vecs[7]  = '{1'b1, 1'b1, 5'd12, 3'b001, 2'd3, 32'h0, W, 1'b1, 32'hFFFF80FF};
        vecs[8]  = '{1'b1, 1'b1, 5'd13, 3'b101, 2'd2, 32'h0, W, 1'b1, 32'h000080FF};
        vecs[9]  = '{1'b1, 1'b1, 5'd14, 3'b010, 2'd1, 32'h0, W, 1'b1, W};
        vecs[10] = '{1'b1, 1'b1, 5'd15, 3'b011, 2'd0, 32'h0, W, 1'b1, W};
        vecs[11] = '{1'b1, 1'b1, 5'd16, 3'b110, 2'd0, 32'h0, W, 1'b1, W};
        vecs[12] = '{1'b1, 1'b1, 5'd17, 3'b111, 2'd0, 32'h0, W, 1'b1, W};
        vecs[13] = '{1'b1, 1'b0, 5'd31, 3'b000, 2'd3, 32'hDEADBEEF, W, 1'b1, 32'hDEADBEEF};
        vecs[14] = '{1'b1, 1'b1, 5'd0,  3'b010, 2'd0, 32'h1234, W, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 1'b0, 5'd3,  3'b010, 2'd0, 32'h5678, W, 1'b0, 32'h0};

        // ---------------- reset state ----------------
        drive(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        bus.wr_ready_i = 1'b1;
        bus.hz_rs1_i   = 5'd1;
        bus.hz_rs2_i   = 5'd0;
        step();
        step();
        check("rst_wv", bus.WriteValid, 1'b0);
        check("rst_ready", bus.ready_o, 1'b0);
        check("rst_hazard", bus.hazard_o, 1'b0);
        check("rst_waddr", bus.WriteAddress, 5'd0);
        check("rst_wdata", bus.WriteData, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.ready_o, 1'b1);
        check_instret("rst_instret");

        // ---------------- x0 / non-writing drop ----------------
        drive(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 2'd0, 32'hAAAA, 32'h0);
        step();
        check("x0_wv", bus.WriteValid, 1'b0);
        check("x0_ready", bus.ready_o, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 5'd7, 3'd0, 2'd0, 32'hBBBB, 32'h0);
        step();
        check("nw_wv", bus.WriteValid, 1'b0);
        check("nw_ready", bus.ready_o, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        step();
        check("drop_wv", bus.WriteValid, 1'b0);
`ifdef WB_INSTRET_EN
        exp_instret = 2;
`endif
        check_instret("drop_instret");

        // ---------------- table-driven single instructions ----------------
        last_addr = 5'd0;
        last_data = 32'd0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vecs[i].rw, vecs[i].m2r, vecs[i].rd, vecs[i].f3, vecs[i].off,
                  vecs[i].alu, vecs[i].rdata);
            bus.wr_ready_i = 1'b1;
            #1;
            check($sformatf("v%0d_ready", i), bus.ready_o, 1'b1);
            step();
            if (vecs[i].exp_wv) begin
                last_addr = vecs[i].rd;
                last_data = vecs[i].exp_data;
            end
            check($sformatf("v%0d_wv", i), bus.WriteValid, vecs[i].exp_wv);
            check($sformatf("v%0d_waddr", i), bus.WriteAddress, last_addr);
            check($sformatf("v%0d_wdata", i), bus.WriteData, last_data);
            bus.valid_i = 1'b0;
            step();
            check($sformatf("v%0d_drain_wv", i), bus.WriteValid, 1'b0);
`ifdef WB_INSTRET_EN
            exp_instret = exp_instret + 1;
`endif
            check_instret($sformatf("v%0d_instret", i));
        end

        // ---------------- backpressure fill ----------------
        bus.wr_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd1, 3'd0, 2'd0, 32'h11, 32'h0);
        step();
        check("bp1_wv", bus.WriteValid, 1'b1);
        check("bp1_waddr", bus.WriteAddress, 5'd1);
        check("bp1_wdata", bus.WriteData, 32'h11);
        check("bp1_ready", bus.ready_o, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 5'd2, 3'd0, 2'd0, 32'h22, 32'h0);
        step();
        check("bp2_ready", bus.ready_o, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 5'd3, 3'd0, 2'd0, 32'h33, 32'h0);
        step();
        check("bp3_ready", bus.ready_o, 1'b0);
        check("bp3_waddr", bus.WriteAddress, 5'd1);
        check("bp3_wdata", bus.WriteData, 32'h11);
        bus.hz_rs1_i = 5'd2; bus.hz_rs2_i = 5'd0; #1;
        check("hz_rs1_2", bus.hazard_o, 1'b1);
        bus.hz_rs1_i = 5'd3; #1;
        check("hz_rs1_3", bus.hazard_o, 1'b0);
        bus.hz_rs2_i = 5'd1; #1;
        check("hz_rs2_1", bus.hazard_o, 1'b1);
        bus.hz_rs1_i = 5'd0; bus.hz_rs2_i = 5'd0; #1;
        check("hz_zero", bus.hazard_o, 1'b0);
        bus.wr_ready_i = 1'b1;
        #1;
        check("drain0_wdata", bus.WriteData, 32'h11);
        check("drain0_ready", bus.ready_o, 1'b0);
        step();
        check("drain1_wv", bus.WriteValid, 1'b1);
        check("drain1_wdata", bus.WriteData, 32'h22);
        check("drain1_ready", bus.ready_o, 1'b1);
        step();
        bus.valid_i = 1'b0;
        check("drain2_wv", bus.WriteValid, 1'b1);
        check("drain2_waddr", bus.WriteAddress, 5'd3);
        check("drain2_wdata", bus.WriteData, 32'h33);
        step();
        check("drain3_wv", bus.WriteValid, 1'b0);
        check("drain3_hold", bus.WriteData, 32'h33);
`ifdef WB_INSTRET_EN
        exp_instret = exp_instret + 3;
`endif
        check_instret("bp_instret");

        // ---------------- streaming ----------------
        bus.wr_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'(i + 1), 3'd0, 2'd0, 32'h100 + 32'(i), 32'h0);
            #1;
            check($sformatf("st%0d_ready", i), bus.ready_o, 1'b1);
            step();
            check($sformatf("st%0d_wv", i), bus.WriteValid, 1'b1);
            check($sformatf("st%0d_waddr", i), bus.WriteAddress, 5'(i + 1));
            check($sformatf("st%0d_wdata", i), bus.WriteData, 32'h100 + 32'(i));
        end
        bus.valid_i = 1'b0;
        step();
        check("st_end_wv", bus.WriteValid, 1'b0);
`ifdef WB_INSTRET_EN
        exp_instret = exp_instret + 10;
`endif
        check_instret("st_instret");

        // ---------------- reset mid-drain ----------------
        bus.wr_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd9, 3'd0, 2'd0, 32'hAA, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd10, 3'd0, 2'd0, 32'hBB, 32'h0);
        step();
        bus.valid_i  = 1'b0;
        bus.hz_rs1_i = 5'd9;
        #1;
        check("rmd_hz_before", bus.hazard_o, 1'b1);
        rst = 1'b1;
        bus.wr_ready_i = 1'b1;
        #1;
        check("rmd_wv_in_rst", bus.WriteValid, 1'b0);
        check("rmd_ready_in_rst", bus.ready_o, 1'b0);
        check("rmd_hz_in_rst", bus.hazard_o, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("rmd_wv", bus.WriteValid, 1'b0);
        check("rmd_waddr", bus.WriteAddress, 5'd0);
        check("rmd_wdata", bus.WriteData, 32'd0);
        check("rmd_hz", bus.hazard_o, 1'b0);
        check("rmd_ready", bus.ready_o, 1'b1);
`ifdef WB_INSTRET_EN
        exp_instret = 0;
`endif
        check_instret("rmd_instret");
        step();
        check("rmd_after_wv", bus.WriteValid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Accepts retiring instructions from the memory stage and formats load data by funct3/byte offset. Selects ALU result or load data, then drives the register-file write port (WriteValid/WriteAddress/WriteData) consumed by decode.
- A small write buffer absorbs cycles where the write port is not granted (wr_ready_i low).
- Provides a hazard query so decode can stall on pending writes.

Parameters:
- DEPTH, 2, write-buffer entries; legal values 2, 4, 8.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- valid_i  in  1  memory stage presents an instruction
- ready_o  out  1  stage can accept; transfer when valid_i && ready_o
- RegWrite_i  in  1  instruction writes rd
- MemToReg_i  in  1  1 = write formatted load data, 0 = ALU result
- rd_i  in  5  destination register
- funct3_i  in  3  load size/sign code
- addr_lo_i  in  2  byte offset of load address
- alu_result_i  in  32  ALU result
- mem_rdata_i  in  32  raw aligned word from data memory
- WriteValid  out  1  register write request
- WriteAddress  out  5  register write address
- WriteData  out  32  register write data
- wr_ready_i  in  1  register-file port grants write this cycle
- hz_rs1_i  in  5  decode rs1 query
- hz_rs2_i  in  5  decode rs2 query
- hazard_o  out  1  buffered write pending to a queried nonzero register

Behaviour:
- Reset (reset_i high at a clock edge): buffer emptied, pointers and count = 0, WriteAddress = 0, WriteData = 0. While reset_i is high, WriteValid = 0, ready_o = 0 and hazard_o = 0. Reset mid-drain discards all buffered writes; no write occurs in the reset cycle.
- Buffer is a circular FIFO of DEPTH entries {rd[4:0], data[31:0]}; pointers wrap modulo DEPTH.
- ready_o = !reset_i && (count != DEPTH).
  - When full, no enqueue occurs even if a dequeue happens the same cycle; ready_o rises the cycle after the dequeue.
- On accept:
  - If RegWrite_i = 0 or rd_i = 0, nothing is enqueued. The instruction retires in the accept cycle and x0 is never written.
  - Otherwise, enqueue {rd_i, MemToReg_i ? fmt : alu_result_i}.
- fmt rules:
  - 000 LB: byte at offset addr_lo_i, sign-extended.
  - 001 LH: halfword at addr_lo_i[1] (bit 0 ignored), sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte at offset addr_lo_i, zero-extended.
  - 101 LHU: halfword at addr_lo_i[1], zero-extended.
  - 011, 110, 111: full word.
- Output side:
  - WriteValid = (count != 0); WriteAddress and WriteData = head entry, driven from registers.
  - When count = 0, WriteAddress and WriteData hold their last values (0 after reset).
  - Dequeue when WriteValid && wr_ready_i; the head advances at that edge.
  - WriteValid, WriteAddress and WriteData are stable while wr_ready_i is low.
- Latency: accept at edge N into an empty buffer gives WriteValid = 1 after edge N. The write commits at the first edge ≥ N+1 with wr_ready_i = 1.
  - Throughput is one write per cycle with wr_ready_i held high.
  - Simultaneous enqueue and dequeue keeps count unchanged.
- hazard_o = 1 iff any valid entry has rd == hz_rs1_i (hz_rs1_i ≠ 0) or rd == hz_rs2_i (hz_rs2_i ≠ 0). Purely combinational from buffer state; the incoming instruction is not included.
- Program order is preserved; there is no write combining.

Optional Feature:
- Macro WB_INSTRET_EN.
- When defined:
  - Adds output port instret_o [63:0], reset to 0.
  - Increments by 1 for each accepted non-writing instruction and by 1 for each committed write (dequeue).
  - Both events in the same cycle increment by 2.
  - Wraps modulo 2^64.
- When undefined: port and counter absent; the rest of the behaviour is identical.

Test Plan:
- LB sign extension: mem_rdata_i=0x80FF7F01, funct3=000, addr_lo=3, rd=5, MemToReg=1, wr_ready_i=1 -> next cycle WriteValid=1, WriteAddress=5, WriteData=0xFFFFFF80.
- LHU/LH: same word, funct3=101, addr_lo=2 -> WriteData=0x000080FF; funct3=001, addr_lo=3 -> 0xFFFF80FF.
- x0 and non-writing drop: rd=0 RegWrite=1, then rd=7 RegWrite=0 -> WriteValid never asserted, ready_o stays 1; with WB_INSTRET_EN, instret_o=2.
- Backpressure fill: wr_ready_i=0, three ALU writes (rd 1,2,3, data 0x11,0x22,0x33), DEPTH=2 -> third held while ready_o=0; hazard_o=1 for hz_rs1_i=2 and 0 for hz_rs1_i=3. After wr_ready_i=1: writes 0x11, 0x22, 0x33 in order on consecutive cycles.
- Streaming: wr_ready_i=1, valid_i high for 10 cycles -> ready_o constantly 1, 10 writes on consecutive cycles, count ≤ 1.
- Reset mid-drain: two buffered entries, assert reset_i one cycle -> WriteValid=0, WriteAddress=0, WriteData=0, hazard_o=0, no write committed; ready_o=1 the cycle after reset deasserts.
